// File: rtl/bp_me_pkg.sv
// Shared memory-end types: arbiter FSM states, transaction kind and the owner-id width macro.
`ifndef BSG_SAFE_CLOG2
`define BSG_SAFE_CLOG2(x) (((x) == 1) ? 1 : $clog2(x))
`endif

`ifndef BP_ME_MEM_ARB_OWNER_WIDTH
`define BP_ME_MEM_ARB_OWNER_WIDTH(num_cce_p) `BSG_SAFE_CLOG2(num_cce_p)
`endif

package bp_me_pkg;

  typedef enum logic [1:0] {
    eIdle,
    eIssue,
    eWait
  } bp_me_mem_arb_state_e;

  typedef enum logic {
    e_kind_cmd,
    e_kind_data_cmd
  } bp_me_mem_arb_kind_e;

endpackage

// File: rtl/bp_me_mem_arb_rr.sv
// Combinational round-robin picker: first requester at or after rr_ptr, wrapping at num_cce_p.
module bp_me_mem_arb_rr
  import bp_me_pkg::*;
#(
  parameter int num_cce_p     = 2,
  parameter int owner_width_p = `BP_ME_MEM_ARB_OWNER_WIDTH(num_cce_p)
) (
  input  logic [owner_width_p-1:0] rr_ptr,
  input  logic [num_cce_p-1:0]     req,
  output logic [owner_width_p-1:0] grant_id,
  output logic                     grant_v
);

  localparam int sum_w_lp = owner_width_p + 1;

  logic [sum_w_lp-1:0]      sum;
  logic [owner_width_p-1:0] idx;

  always_comb begin
    // NOTE: every output and temporary gets a default before the loop so no latch is inferred.
    grant_id = '0;
    grant_v  = 1'b0;
    sum      = '0;
    idx      = '0;
    // Scan from the farthest offset back to rr_ptr so the nearest requester is the last writer.
    for (int i = num_cce_p - 1; i >= 0; i--) begin
      sum = {1'b0, rr_ptr} + sum_w_lp'(i);
      if (sum >= sum_w_lp'(num_cce_p)) sum = sum - sum_w_lp'(num_cce_p);
      idx = sum[owner_width_p-1:0];
      if (req[idx]) begin
        grant_v  = 1'b1;
        grant_id = idx;
      end
    end
  end

endmodule

// File: rtl/bp_me_mem_arbiter.sv
// Round-robin share of one bp_mem port among num_cce_p CCEs, one transaction in flight.
// Optional watchdog enabled by defining BP_ME_MEM_ARB_TIMEOUT_EN.
module bp_me_mem_arbiter
  import bp_me_pkg::*;
#(
  parameter int num_cce_p         = 2,
  parameter int cmd_width_p       = 0,
  parameter int data_cmd_width_p  = 0,
  parameter int resp_width_p      = 0,
  parameter int data_resp_width_p = 0,
  parameter int timeout_cycles_p  = 4096
) (
  input  logic                                         clk_i,
  input  logic                                         reset_i,

  input  logic [num_cce_p-1:0][cmd_width_p-1:0]        mem_cmd_i,
  input  logic [num_cce_p-1:0]                         mem_cmd_v_i,
  output logic [num_cce_p-1:0]                         mem_cmd_yumi_o,

  input  logic [num_cce_p-1:0][data_cmd_width_p-1:0]   mem_data_cmd_i,
  input  logic [num_cce_p-1:0]                         mem_data_cmd_v_i,
  output logic [num_cce_p-1:0]                         mem_data_cmd_yumi_o,

  output logic [num_cce_p-1:0][resp_width_p-1:0]       mem_resp_o,
  output logic [num_cce_p-1:0]                         mem_resp_v_o,
  input  logic [num_cce_p-1:0]                         mem_resp_ready_i,

  output logic [num_cce_p-1:0][data_resp_width_p-1:0]  mem_data_resp_o,
  output logic [num_cce_p-1:0]                         mem_data_resp_v_o,
  input  logic [num_cce_p-1:0]                         mem_data_resp_ready_i,

  output logic [cmd_width_p-1:0]                       mem_cmd_o,
  output logic                                         mem_cmd_v_o,
  input  logic                                         mem_cmd_yumi_i,

  output logic [data_cmd_width_p-1:0]                  mem_data_cmd_o,
  output logic                                         mem_data_cmd_v_o,
  input  logic                                         mem_data_cmd_yumi_i,

  input  logic [resp_width_p-1:0]                      mem_resp_i,
  input  logic                                         mem_resp_v_i,
  output logic                                         mem_resp_ready_o,

  input  logic [data_resp_width_p-1:0]                 mem_data_resp_i,
  input  logic                                         mem_data_resp_v_i,
  output logic                                         mem_data_resp_ready_o,

  output logic                                         timeout_o
);

  localparam int owner_width_lp = `BP_ME_MEM_ARB_OWNER_WIDTH(num_cce_p);

  if (num_cce_p < 1) begin : g_bad_num_cce
    $error("bp_me_mem_arbiter: num_cce_p must be at least 1");
  end
  if (timeout_cycles_p < 1 || timeout_cycles_p > 65536) begin : g_bad_timeout
    $error("bp_me_mem_arbiter: timeout_cycles_p must fit the 16-bit watchdog");
  end

  bp_me_mem_arb_state_e      state_r;
  bp_me_mem_arb_kind_e       kind_r;
  logic [owner_width_lp-1:0] owner_r;
  logic [owner_width_lp-1:0] rr_ptr_r;
  logic [owner_width_lp-1:0] rr_next;
  logic [owner_width_lp-1:0] grant_id;
  logic                      grant_v;
  logic [num_cce_p-1:0]      req;

  logic is_cmd;
  logic issue_cmd, issue_data_cmd;
  logic wait_cmd, wait_data_cmd;
  logic issue_done, resp_done;

  assign req = mem_cmd_v_i | mem_data_cmd_v_i;

  bp_me_mem_arb_rr #(
    .num_cce_p    (num_cce_p),
    .owner_width_p(owner_width_lp)
  ) rr (
    .rr_ptr  (rr_ptr_r),
    .req     (req),
    .grant_id(grant_id),
    .grant_v (grant_v)
  );

  assign is_cmd         = (kind_r == e_kind_cmd);
  assign issue_cmd      = (state_r == eIssue) &  is_cmd;
  assign issue_data_cmd = (state_r == eIssue) & ~is_cmd;
  assign wait_cmd       = (state_r == eWait)  &  is_cmd;
  assign wait_data_cmd  = (state_r == eWait)  & ~is_cmd;

  assign mem_cmd_o        = mem_cmd_i[owner_r];
  assign mem_data_cmd_o   = mem_data_cmd_i[owner_r];
  assign mem_cmd_v_o      = issue_cmd      & mem_cmd_v_i[owner_r];
  assign mem_data_cmd_v_o = issue_data_cmd & mem_data_cmd_v_i[owner_r];

  // A read returns on the data-resp channel, a writeback on the resp channel.
  assign mem_data_resp_ready_o = wait_cmd      & mem_data_resp_ready_i[owner_r];
  assign mem_resp_ready_o      = wait_data_cmd & mem_resp_ready_i[owner_r];

  assign mem_resp_o      = {num_cce_p{mem_resp_i}};
  assign mem_data_resp_o = {num_cce_p{mem_data_resp_i}};

  always_comb begin
    mem_cmd_yumi_o      = '0;
    mem_data_cmd_yumi_o = '0;
    mem_resp_v_o        = '0;
    mem_data_resp_v_o   = '0;
    mem_cmd_yumi_o[owner_r]      = mem_cmd_v_o      & mem_cmd_yumi_i;
    mem_data_cmd_yumi_o[owner_r] = mem_data_cmd_v_o & mem_data_cmd_yumi_i;
    mem_resp_v_o[owner_r]        = wait_data_cmd    & mem_resp_v_i;
    mem_data_resp_v_o[owner_r]   = wait_cmd         & mem_data_resp_v_i;
  end

  assign issue_done = (mem_cmd_v_o & mem_cmd_yumi_i) | (mem_data_cmd_v_o & mem_data_cmd_yumi_i);
  assign resp_done  = (mem_resp_v_i & mem_resp_ready_o)
                    | (mem_data_resp_v_i & mem_data_resp_ready_o);
  assign rr_next    = (owner_r == owner_width_lp'(num_cce_p - 1)) ? '0 : owner_r + 1'b1;

`ifdef BP_ME_MEM_ARB_TIMEOUT_EN
  localparam logic [15:0] timeout_lim_lp = 16'(timeout_cycles_p - 1);
  logic [15:0] wait_cnt_r;
  logic        timeout_r;
  assign timeout_o = timeout_r;
`else
  assign timeout_o = 1'b0;
`endif

  // NOTE: all state is updated with non-blocking assignments so every branch sees pre-edge values.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_r    <= eIdle;
      kind_r     <= e_kind_cmd;
      owner_r    <= '0;
      rr_ptr_r   <= '0;
`ifdef BP_ME_MEM_ARB_TIMEOUT_EN
      wait_cnt_r <= '0;
      timeout_r  <= 1'b0;
`endif
    end else begin
      case (state_r)
        eIdle: begin
          if (grant_v) begin
            owner_r <= grant_id;
            kind_r  <= mem_data_cmd_v_i[grant_id] ? e_kind_data_cmd : e_kind_cmd;
            state_r <= eIssue;
          end
        end
        eIssue: begin
          if (issue_done) begin
            state_r    <= eWait;
`ifdef BP_ME_MEM_ARB_TIMEOUT_EN
            wait_cnt_r <= '0;
`endif
          end
        end
        eWait: begin
          if (resp_done) begin
            rr_ptr_r <= rr_next;
            state_r  <= eIdle;
          end
`ifdef BP_ME_MEM_ARB_TIMEOUT_EN
          else if (wait_cnt_r == timeout_lim_lp) begin
            // Abandon the transaction but keep rotating so the stuck CCE cannot hog the port.
            timeout_r <= 1'b1;
            rr_ptr_r  <= rr_next;
            state_r   <= eIdle;
          end else begin
            wait_cnt_r <= wait_cnt_r + 1'b1;
          end
`endif
        end
        default: state_r <= eIdle;
      endcase
    end
  end

  a_no_unexpected_resp : assert property (@(posedge clk_i) disable iff (reset_i)
    (state_r == eWait) |-> !(is_cmd ? mem_resp_v_i : mem_data_resp_v_i));

endmodule
